// File: rtl/if_result_window_pkg.sv
// Shared types and helpers for the if_result_window stage: FSM state encoding and
// derivation of the window-sum width.
package if_result_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_e;

    // The sum of WIN samples of DW bits needs $clog2(WIN) extra bits to never overflow.
    function automatic int sum_width(input int dw, input int win);
        return dw + $clog2(win);
    endfunction

endpackage

// File: rtl/if_result_window_minmax_track.sv
// Running per-window minimum/maximum tracker used by if_result_window when
// IF_RESULT_MINMAX_EN is defined; exposes the post-accept values combinationally.
module if_minmax_track #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          load,
    input  logic          update,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] min_nxt,
    output logic [DW-1:0] max_nxt
);

    logic [DW-1:0] min_q, min_d;
    logic [DW-1:0] max_q, max_d;

    always_comb begin
        min_nxt = min_q;
        max_nxt = max_q;
        if (load) begin
            min_nxt = din;
            max_nxt = din;
        end else if (update) begin
            min_nxt = (din < min_q) ? din : min_q;
            max_nxt = (din > max_q) ? din : max_q;
        end
    end

    always_comb begin
        min_d = clr ? '1 : min_nxt;
        max_d = clr ? '0 : max_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_q <= '1;
            max_q <= '0;
        end else begin
            min_q <= min_d;
            max_q <= max_d;
        end
    end

endmodule

// File: rtl/if_result_window.sv
// Groups WIN consecutive XOUT samples into a window and presents the window SUM
// (plus MIN/MAX when IF_RESULT_MINMAX_EN is defined) through a valid/ready register.
module if_result_window
    import if_result_pkg::*;
#(
    parameter  int DW  = 16,
    parameter  int WIN = 4,
    localparam int SW  = sum_width(DW, WIN)
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          CLR,
    input  logic          IN_VALID,
    output logic          IN_READY,
    input  logic [DW-1:0] XOUT,
    output logic          OUT_VALID,
    input  logic          OUT_READY,
`ifdef IF_RESULT_MINMAX_EN
    output logic [DW-1:0] MIN,
    output logic [DW-1:0] MAX,
`endif
    output logic [SW-1:0] SUM
);

    localparam int CW = $clog2(WIN);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] acc_q, acc_d;
    logic [SW-1:0] sum_q, sum_d;
    logic [SW-1:0] xz;
    logic          accept;
    logic          pop;
    logic          acc_first;
    logic          acc_last;

    // Reset gates IN_READY so an upstream valid is never taken while RST_N is low.
    assign IN_READY  = RST_N & ~CLR & ((state_q != HOLD) | OUT_READY);
    assign OUT_VALID = (state_q == HOLD);
    assign accept    = IN_VALID & IN_READY;
    assign pop       = OUT_VALID & OUT_READY;
    assign xz        = SW'(XOUT);
    assign acc_first = accept & (state_q != ACCUM);
    assign acc_last  = accept & (state_q == ACCUM) & (cnt_q == CW'(WIN - 1));
    assign SUM       = sum_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        if (CLR) begin
            state_d = IDLE;
            cnt_d   = '0;
            acc_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_d = ACCUM;
                        acc_d   = xz;
                        cnt_d   = CW'(1);
                    end
                end
                ACCUM: begin
                    if (acc_last) begin
                        state_d = HOLD;
                        sum_d   = acc_q + xz;
                        acc_d   = '0;
                        cnt_d   = '0;
                    end else if (accept) begin
                        acc_d = acc_q + xz;
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                HOLD: begin
                    // A sample is only accepted here alongside a pop, so the next window
                    // starts without a bubble.
                    if (pop) begin
                        if (accept) begin
                            state_d = ACCUM;
                            acc_d   = xz;
                            cnt_d   = CW'(1);
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
        end
    end

`ifdef IF_RESULT_MINMAX_EN
    logic [DW-1:0] min_nxt, max_nxt;
    logic [DW-1:0] min_q, min_d;
    logic [DW-1:0] max_q, max_d;

    if_minmax_track #(
        .DW(DW)
    ) u_minmax (
        .clk    (CLK),
        .rst_n  (RST_N),
        .clr    (CLR),
        .load   (acc_first),
        .update (accept & ~acc_first),
        .din    (XOUT),
        .min_nxt(min_nxt),
        .max_nxt(max_nxt)
    );

    always_comb begin
        min_d = acc_last ? min_nxt : min_q;
        max_d = acc_last ? max_nxt : max_q;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            min_q <= '1;
            max_q <= '0;
        end else begin
            min_q <= min_d;
            max_q <= max_d;
        end
    end

    assign MIN = min_q;
    assign MAX = max_q;
`endif

endmodule

// File: tb/tb_if_result_window.sv
// Self-checking bench for if_result_window: table-driven windows, hand-written
// handshake/clear/reset sequences, then randomized traffic against a queue model.
module tb_if_result_window;

    localparam int DW  = 16;
    localparam int WIN = 4;
    localparam int SW  = DW + $clog2(WIN);

    logic          CLK = 1'b0;
    logic          RST_N;
    logic          CLR;
    logic          IN_VALID;
    logic          IN_READY;
    logic [DW-1:0] XOUT;
    logic          OUT_VALID;
    logic          OUT_READY;
    logic [SW-1:0] SUM;
`ifdef IF_RESULT_MINMAX_EN
    logic [DW-1:0] MIN;
    logic [DW-1:0] MAX;
`endif

    int checks   = 0;
    int failures = 0;

    if_result_window #(.DW(DW), .WIN(WIN)) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .CLR      (CLR),
        .IN_VALID (IN_VALID),
        .IN_READY (IN_READY),
        .XOUT     (XOUT),
        .OUT_VALID(OUT_VALID),
        .OUT_READY(OUT_READY),
`ifdef IF_RESULT_MINMAX_EN
        .MIN      (MIN),
        .MAX      (MAX),
`endif
        .SUM      (SUM)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [DW-1:0] s [WIN];
        logic [SW-1:0] exp_sum;
        logic [DW-1:0] exp_min;
        logic [DW-1:0] exp_max;
    } win_vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] v);
        IN_VALID = 1'b1;
        XOUT     = v;
        tick();
        IN_VALID = 1'b0;
    endtask

    win_vec_t vecs [4];

    // Randomized model state: the samples of the open window and the pending result.
    logic [DW-1:0] m_win [$];
    bit            m_have;
    logic [SW-1:0] m_sum;
    logic [DW-1:0] m_min, m_max;

    initial begin
        vecs[0].s = '{16'd1, 16'd2, 16'd3, 16'd4};
        vecs[0].exp_sum = 18'd10;     vecs[0].exp_min = 16'd1;   vecs[0].exp_max = 16'd4;
        vecs[1].s = '{16'd0, 16'd0, 16'd0, 16'd0};
        vecs[1].exp_sum = 18'd0;      vecs[1].exp_min = 16'd0;   vecs[1].exp_max = 16'd0;
        vecs[2].s = '{16'hFFFF, 16'd1, 16'hFFFF, 16'd0};
        vecs[2].exp_sum = 18'h1FFFF;  vecs[2].exp_min = 16'd0;   vecs[2].exp_max = 16'hFFFF;
        vecs[3].s = '{16'd100, 16'd50, 16'd200, 16'd25};
        vecs[3].exp_sum = 18'd375;    vecs[3].exp_min = 16'd25;  vecs[3].exp_max = 16'd200;

        RST_N = 1'b0; CLR = 1'b0; IN_VALID = 1'b0; XOUT = '0; OUT_READY = 1'b1;
        #2;
        chk("reset_in_ready", IN_READY, 1'b0);
        chk("reset_out_valid", OUT_VALID, 1'b0);
        chk("reset_sum", SUM, '0);
`ifdef IF_RESULT_MINMAX_EN
        chk("reset_min", MIN, 16'hFFFF);
        chk("reset_max", MAX, 16'h0000);
`endif
        tick(); tick();
        RST_N = 1'b1;
        #1;
        chk("post_reset_in_ready", IN_READY, 1'b1);

        // Table-driven windows with the consumer always ready.
        for (int v = 0; v < 4; v++) begin
            OUT_READY = 1'b1;
            for (int k = 0; k < WIN; k++) begin
                IN_VALID = 1'b1;
                XOUT     = vecs[v].s[k];
                #1;
                chk($sformatf("tbl%0d_in_ready_%0d", v, k), IN_READY, 1'b1);
                if (k == WIN - 1) chk($sformatf("tbl%0d_early_valid", v), OUT_VALID, 1'b0);
                tick();
            end
            IN_VALID = 1'b0;
            #1;
            chk($sformatf("tbl%0d_out_valid", v), OUT_VALID, 1'b1);
            chk($sformatf("tbl%0d_sum", v), SUM, vecs[v].exp_sum);
`ifdef IF_RESULT_MINMAX_EN
            chk($sformatf("tbl%0d_min", v), MIN, vecs[v].exp_min);
            chk($sformatf("tbl%0d_max", v), MAX, vecs[v].exp_max);
`endif
            tick();
            chk($sformatf("tbl%0d_popped", v), OUT_VALID, 1'b0);
        end

        // Back-pressure: result held, then pop and accept in the same cycle.
        send(16'd10); send(16'd20); send(16'd30); send(16'd40);
        OUT_READY = 1'b0; IN_VALID = 1'b1; XOUT = 16'd99;
        #1;
        chk("hold_out_valid", OUT_VALID, 1'b1);
        chk("hold_sum", SUM, 18'd100);
        chk("hold_in_ready", IN_READY, 1'b0);
        tick(); tick();
        chk("hold_still_valid", OUT_VALID, 1'b1);
        chk("hold_still_sum", SUM, 18'd100);
        OUT_READY = 1'b1; XOUT = 16'd7;
        #1;
        chk("pop_accept_in_ready", IN_READY, 1'b1);
        tick();
        IN_VALID = 1'b0;
        chk("pop_accept_valid_drop", OUT_VALID, 1'b0);
        send(16'd1); send(16'd1);
        chk("pop_accept_not_done", OUT_VALID, 1'b0);
        send(16'd1);
        chk("pop_accept_window_valid", OUT_VALID, 1'b1);
        chk("pop_accept_window_sum", SUM, 18'd10);
        tick();

        // Eight back-to-back full-scale samples: two results, no bubble.
        OUT_READY = 1'b1;
        for (int k = 0; k < 2 * WIN; k++) begin
            IN_VALID = 1'b1; XOUT = 16'hFFFF;
            #1;
            chk($sformatf("b2b_in_ready_%0d", k), IN_READY, 1'b1);
            tick();
            if (k % WIN == WIN - 1) begin
                chk($sformatf("b2b_valid_%0d", k), OUT_VALID, 1'b1);
                chk($sformatf("b2b_sum_%0d", k), SUM, 18'h3FFFC);
            end else begin
                chk($sformatf("b2b_idle_%0d", k), OUT_VALID, 1'b0);
            end
        end
        IN_VALID = 1'b0;
        tick();

        // Clear drops a partial window; the sample presented with CLR is ignored.
        send(16'd9); send(16'd9);
        CLR = 1'b1; IN_VALID = 1'b1; XOUT = 16'd50;
        #1;
        chk("clr_in_ready", IN_READY, 1'b0);
        tick();
        CLR = 1'b0; IN_VALID = 1'b0;
        send(16'd5); send(16'd5); send(16'd5);
        chk("clr_no_early_result", OUT_VALID, 1'b0);
        send(16'd5);
        chk("clr_result_valid", OUT_VALID, 1'b1);
        chk("clr_result_sum", SUM, 18'd20);
`ifdef IF_RESULT_MINMAX_EN
        chk("clr_result_min", MIN, 16'd5);
        chk("clr_result_max", MAX, 16'd5);
`endif
        tick();

        // Asynchronous reset while a result is held.
        send(16'd1); send(16'd2); send(16'd3); send(16'd4);
        OUT_READY = 1'b0;
        #1;
        chk("rst_hold_valid", OUT_VALID, 1'b1);
        #1;
        OUT_READY = 1'b1;
        RST_N = 1'b0;
        #1;
        chk("rst_async_out_valid", OUT_VALID, 1'b0);
        chk("rst_async_sum", SUM, '0);
        chk("rst_async_in_ready", IN_READY, 1'b0);
        tick();
        RST_N = 1'b1; OUT_READY = 1'b0;
        #1;
        chk("rst_release_in_ready", IN_READY, 1'b1);
        tick();

        // Randomized traffic against the queue model.
        m_win.delete();
        m_have = 1'b0;
        m_sum = '0;
        for (int c = 0; c < 3000; c++) begin
            logic exp_ready;
            CLR       = ($urandom_range(0, 39) == 0);
            IN_VALID  = ($urandom_range(0, 3) != 0);
            OUT_READY = ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 3))
                0:       XOUT = 16'hFFFF;
                1:       XOUT = 16'(($urandom_range(0, 15)));
                default: XOUT = 16'($urandom);
            endcase
            #1;
            exp_ready = !CLR && (!m_have || OUT_READY);
            chk("rnd_in_ready", IN_READY, exp_ready);
            chk("rnd_out_valid", OUT_VALID, m_have);
            if (m_have) begin
                chk("rnd_sum", SUM, m_sum);
`ifdef IF_RESULT_MINMAX_EN
                chk("rnd_min", MIN, m_min);
                chk("rnd_max", MAX, m_max);
`endif
            end
            if (CLR) begin
                m_win.delete();
                m_have = 1'b0;
            end else begin
                if (m_have && OUT_READY) m_have = 1'b0;
                if (IN_VALID && exp_ready) m_win.push_back(XOUT);
                if (m_win.size() == WIN) begin
                    int unsigned s;
                    s = 0;
                    m_min = m_win[0];
                    m_max = m_win[0];
                    foreach (m_win[i]) begin
                        s += m_win[i];
                        if (m_win[i] < m_min) m_min = m_win[i];
                        if (m_win[i] > m_max) m_max = m_win[i];
                    end
                    m_sum  = SW'(s);
                    m_have = 1'b1;
                    m_win.delete();
                end
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
